// File: rtl/frame_ctrl_pkg.sv
// Shared constants for the frame control generator: encoder FSM encoding,
// default scale targets and the frame-start shift register depth helper.
package frame_ctrl_pkg;

  localparam logic [1:0] ST_OFF   = 2'd0;
  localparam logic [1:0] ST_ON    = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  localparam int TGT_H_DEF = 1920;
  localparam int TGT_V_DEF = 1080;
  localparam int FRAC_DEF  = 10;

  // One tap beyond the deepest consumer so edge detects always have a "previous" bit.
  function automatic int fs_depth(input int data_dly, input int en_latch_dly,
                                  input int fs_enc_dly);
    int d;
    d = data_dly;
    if (en_latch_dly + 1 > d) d = en_latch_dly + 1;
    if (fs_enc_dly + 1 > d) d = fs_enc_dly + 1;
    return d + 1;
  endfunction

endpackage

// File: rtl/frame_ctrl_gen_param_seq_udiv.sv
// Restoring unsigned divider, one quotient bit per clock. The start cycle
// already retires the first bit, so done follows start by DIVIDEND_W cycles.
module seq_udiv #(
  parameter int DIVIDEND_W = 26,
  parameter int DIVISOR_W  = 16,
  parameter int QUOT_W     = 26
) (
  input  logic                  sys_clk_i,
  input  logic                  resetn_i,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic                  div_by_zero,
  output logic [QUOT_W-1:0]     quotient
);

  localparam int CNT_W = $clog2(DIVIDEND_W + 1);

  logic [DIVISOR_W-1:0]  rem_q, rem_cur, rem_nxt, dsr_q, dsr_cur;
  logic [DIVISOR_W:0]    rem_shift;
  logic [DIVIDEND_W-1:0] quo_q, quo_cur, quo_nxt;
  logic [CNT_W-1:0]      cnt_q;

  // A start overrides any running division, restarting from the new operands.
  always_comb begin
    rem_cur   = start ? '0 : rem_q;
    quo_cur   = start ? dividend : quo_q;
    dsr_cur   = start ? divisor : dsr_q;
    rem_shift = {rem_cur, quo_cur[DIVIDEND_W-1]};
    rem_nxt   = rem_shift[DIVISOR_W-1:0];
    quo_nxt   = {quo_cur[DIVIDEND_W-2:0], 1'b0};
    if (rem_shift >= {1'b0, dsr_cur}) begin
      rem_nxt = DIVISOR_W'(rem_shift - {1'b0, dsr_cur});
      quo_nxt = {quo_cur[DIVIDEND_W-2:0], 1'b1};
    end
  end

  always_ff @(posedge sys_clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      rem_q       <= '0;
      quo_q       <= '0;
      dsr_q       <= '0;
      cnt_q       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem_q       <= rem_nxt;
        quo_q       <= quo_nxt;
        dsr_q       <= divisor;
        div_by_zero <= (divisor == '0);
        cnt_q       <= CNT_W'(DIVIDEND_W - 1);
        busy        <= 1'b1;
      end else if (busy) begin
        rem_q <= rem_nxt;
        quo_q <= quo_nxt;
        cnt_q <= cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign quotient = quo_q[QUOT_W-1:0];

endmodule

// File: rtl/frame_ctrl_gen_param.sv
// Frame control generator: pixel/frame-start delay line, arithmetic H/V scale
// factors, resolution-change detection and the encoder enable/flush FSM.
module frame_ctrl_gen_param
  import frame_ctrl_pkg::*;
#(
  parameter int PIX_W        = 8,
  parameter int NCH          = 3,
  parameter int DATA_DLY     = 1,
  parameter int RES_W        = 16,
  parameter int SF_W         = 16,
  parameter int FRAC         = FRAC_DEF,
  parameter int TGT_H        = TGT_H_DEF,
  parameter int TGT_V        = TGT_V_DEF,
  parameter int H_SF_RST     = 1535,
  parameter int V_SF_RST     = 1534,
  parameter int HRES_RST     = 1280,
  parameter int VRES_RST     = 720,
  parameter int EN_LATCH_DLY = 3,
  parameter int FS_ENC_DLY   = 18,
  parameter int FLUSH_FRAMES = 1
) (
  input  logic                 sys_clk_i,
  input  logic                 resetn_i,
  input  logic                 encoder_en_i,
  input  logic                 frame_start_i,
  input  logic [RES_W-1:0]     hres_i,
  input  logic [RES_W-1:0]     vres_i,
  input  logic                 data_valid_i,
  input  logic [NCH*PIX_W-1:0] data_i,
  output logic                 data_valid_d_o,
  output logic [NCH*PIX_W-1:0] data_d_o,
  output logic                 frame_start_d_o,
  output logic [SF_W-1:0]      h_scale_factor_o,
  output logic [SF_W-1:0]      v_scale_factor_o,
  output logic                 sf_update_o,
  output logic                 res_change_o,
  output logic                 encoder_en_o,
  output logic                 frame_start_encoder_o,
  output logic                 eof_encoder_o
);

  localparam int FS_D  = fs_depth(DATA_DLY, EN_LATCH_DLY, FS_ENC_DLY);
  localparam int DIV_W = RES_W + FRAC;
  localparam int FC_W  = $clog2(FLUSH_FRAMES + 1);
  localparam logic [DIV_W-1:0] H_DVD  = DIV_W'(TGT_H) << FRAC;
  localparam logic [DIV_W-1:0] V_DVD  = DIV_W'(TGT_V) << FRAC;
  localparam logic [63:0]      SF_MAX = (64'd1 << SF_W) - 64'd1;

  logic [FS_D-1:0]        fs_sr;
  logic [NCH*PIX_W-1:0]   data_pipe [DATA_DLY];
  logic [DATA_DLY-1:0]    valid_pipe;
  logic [RES_W-1:0]       prev_h, prev_v;
  logic                   fs_rise, latch_ev;
  logic                   h_busy, h_done, h_dbz, v_busy, v_done, v_dbz;
  logic [DIV_W-1:0]       h_quot, v_quot;
  logic [1:0]             state, state_nxt;
  logic [FC_W-1:0]        flush_cnt, flush_cnt_nxt;
  logic                   unused_ok;

  function automatic logic [SF_W-1:0] sat_sf(input logic [DIV_W-1:0] q);
    logic [DIV_W-1:0] qm1;
    qm1 = q - DIV_W'(1);
    if (q == '0) return '0;
    if (64'(qm1) > SF_MAX) return '1;
    return SF_W'(qm1);
  endfunction

  always_ff @(posedge sys_clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      fs_sr      <= '0;
      valid_pipe <= '0;
      for (int i = 0; i < DATA_DLY; i++) data_pipe[i] <= '0;
    end else begin
      fs_sr         <= {fs_sr[FS_D-2:0], frame_start_i};
      valid_pipe[0] <= data_valid_i;
      data_pipe[0]  <= data_i;
      for (int i = 1; i < DATA_DLY; i++) begin
        valid_pipe[i] <= valid_pipe[i-1];
        data_pipe[i]  <= data_pipe[i-1];
      end
    end
  end

  assign data_d_o              = data_pipe[DATA_DLY-1];
  assign data_valid_d_o        = valid_pipe[DATA_DLY-1];
  assign frame_start_d_o       = fs_sr[DATA_DLY-1];
  assign frame_start_encoder_o = fs_sr[FS_ENC_DLY] | fs_sr[FS_ENC_DLY-1];
  assign eof_encoder_o         = (fs_sr[0] | fs_sr[1]) & encoder_en_o;
  assign fs_rise               = frame_start_i & ~fs_sr[0];
  assign latch_ev              = fs_sr[EN_LATCH_DLY] & ~fs_sr[EN_LATCH_DLY+1];

  always_ff @(posedge sys_clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      prev_h       <= RES_W'(HRES_RST);
      prev_v       <= RES_W'(VRES_RST);
      res_change_o <= 1'b0;
    end else if (frame_start_i) begin
      prev_h       <= hres_i;
      prev_v       <= vres_i;
      res_change_o <= (hres_i != prev_h) | (vres_i != prev_v);
    end
  end

  seq_udiv #(.DIVIDEND_W(DIV_W), .DIVISOR_W(RES_W), .QUOT_W(DIV_W)) u_h_div (
    .sys_clk_i(sys_clk_i), .resetn_i(resetn_i), .start(fs_rise),
    .dividend(H_DVD), .divisor(hres_i), .busy(h_busy), .done(h_done),
    .div_by_zero(h_dbz), .quotient(h_quot)
  );

  seq_udiv #(.DIVIDEND_W(DIV_W), .DIVISOR_W(RES_W), .QUOT_W(DIV_W)) u_v_div (
    .sys_clk_i(sys_clk_i), .resetn_i(resetn_i), .start(fs_rise),
    .dividend(V_DVD), .divisor(vres_i), .busy(v_busy), .done(v_done),
    .div_by_zero(v_dbz), .quotient(v_quot)
  );

  // A zero resolution keeps the old factor but still signals the update slot.
  always_ff @(posedge sys_clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      h_scale_factor_o <= SF_W'(H_SF_RST);
      v_scale_factor_o <= SF_W'(V_SF_RST);
      sf_update_o      <= 1'b0;
    end else begin
      sf_update_o <= h_done | v_done;
      if (h_done && !h_dbz) h_scale_factor_o <= sat_sf(h_quot);
      if (v_done && !v_dbz) v_scale_factor_o <= sat_sf(v_quot);
    end
  end

  // A resolution change always wins over a simultaneous enable drop.
  always_comb begin
    state_nxt     = state;
    flush_cnt_nxt = flush_cnt;
    if (latch_ev) begin
      case (state)
        ST_OFF: begin
          if (encoder_en_i && res_change_o) begin
            state_nxt     = ST_FLUSH;
            flush_cnt_nxt = FC_W'(FLUSH_FRAMES);
          end else if (encoder_en_i) begin
            state_nxt = ST_ON;
          end
        end
        ST_ON: begin
          if (res_change_o) begin
            state_nxt     = ST_FLUSH;
            flush_cnt_nxt = FC_W'(FLUSH_FRAMES);
          end else if (!encoder_en_i) begin
            state_nxt = ST_OFF;
          end
        end
        ST_FLUSH: begin
          if (res_change_o) begin
            flush_cnt_nxt = FC_W'(FLUSH_FRAMES);
          end else if (flush_cnt <= FC_W'(1)) begin
            flush_cnt_nxt = '0;
            state_nxt     = encoder_en_i ? ST_ON : ST_OFF;
          end else begin
            flush_cnt_nxt = flush_cnt - FC_W'(1);
          end
        end
        default: state_nxt = ST_OFF;
      endcase
    end
  end

  always_ff @(posedge sys_clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state        <= ST_OFF;
      flush_cnt    <= '0;
      encoder_en_o <= 1'b0;
    end else begin
      state        <= state_nxt;
      flush_cnt    <= flush_cnt_nxt;
      encoder_en_o <= (state_nxt == ST_ON);
    end
  end

  assign unused_ok = ^{h_busy, v_busy, fs_sr};

endmodule

// File: tb/tb_frame_ctrl_gen_param.sv
// Directed bench for frame_ctrl_gen_param with a 4-channel, 3-deep pixel pipe.
module tb_frame_ctrl_gen_param;

  localparam int PIX_W = 8, NCH = 4, DATA_DLY = 3, RES_W = 16, SF_W = 16;
  localparam int DW = NCH * PIX_W;

  logic              sys_clk_i = 1'b0;
  logic              resetn_i = 1'b0;
  logic              encoder_en_i = 1'b0;
  logic              frame_start_i = 1'b0;
  logic [RES_W-1:0]  hres_i = 16'd1280;
  logic [RES_W-1:0]  vres_i = 16'd720;
  logic              data_valid_i = 1'b0;
  logic [DW-1:0]     data_i = '0;
  logic              data_valid_d_o;
  logic [DW-1:0]     data_d_o;
  logic              frame_start_d_o;
  logic [SF_W-1:0]   h_scale_factor_o, v_scale_factor_o;
  logic              sf_update_o, res_change_o, encoder_en_o;
  logic              frame_start_encoder_o, eof_encoder_o;

  int checks = 0;
  int failures = 0;

  always #5 sys_clk_i = ~sys_clk_i;

  frame_ctrl_gen_param #(.PIX_W(PIX_W), .NCH(NCH), .DATA_DLY(DATA_DLY)) u_dut (
    .sys_clk_i(sys_clk_i), .resetn_i(resetn_i), .encoder_en_i(encoder_en_i),
    .frame_start_i(frame_start_i), .hres_i(hres_i), .vres_i(vres_i),
    .data_valid_i(data_valid_i), .data_i(data_i),
    .data_valid_d_o(data_valid_d_o), .data_d_o(data_d_o),
    .frame_start_d_o(frame_start_d_o), .h_scale_factor_o(h_scale_factor_o),
    .v_scale_factor_o(v_scale_factor_o), .sf_update_o(sf_update_o),
    .res_change_o(res_change_o), .encoder_en_o(encoder_en_o),
    .frame_start_encoder_o(frame_start_encoder_o), .eof_encoder_o(eof_encoder_o)
  );

  task automatic tick;
    @(posedge sys_clk_i);
    #1;
  endtask

  task automatic apply_reset;
    resetn_i = 1'b0;
    encoder_en_i = 1'b0;
    frame_start_i = 1'b0;
    hres_i = 16'd1280;
    vres_i = 16'd720;
    data_valid_i = 1'b0;
    data_i = '0;
    tick();
    tick();
    resetn_i = 1'b1;
    tick();
  endtask

  // Raises frame_start_i for one cycle; returns in the cycle after the pulse.
  task automatic pulse_fs(input logic [RES_W-1:0] h, input logic [RES_W-1:0] v);
    hres_i = h;
    vres_i = v;
    frame_start_i = 1'b1;
    tick();
    frame_start_i = 1'b0;
  endtask

  task automatic run_frame(input logic [RES_W-1:0] h, input logic [RES_W-1:0] v,
                           output int first, output int pulses);
    pulse_fs(h, v);
    first = -1;
    pulses = 0;
    for (int n = 1; n <= 40; n++) begin
      if (sf_update_o) begin
        pulses++;
        if (first < 0) first = n;
      end
      tick();
    end
  endtask

  task automatic test_reset;
    apply_reset();
    checks++; if (h_scale_factor_o !== 16'd1535) begin failures++; $display("[TB] FAIL reset_h_sf: got %0d expected 1535", h_scale_factor_o); end
    checks++; if (v_scale_factor_o !== 16'd1534) begin failures++; $display("[TB] FAIL reset_v_sf: got %0d expected 1534", v_scale_factor_o); end
    checks++; if (encoder_en_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_enc: got %0b expected 0", encoder_en_o); end
    checks++; if (data_d_o !== '0) begin failures++; $display("[TB] FAIL reset_data: got %h expected 0", data_d_o); end
    checks++; if (data_valid_d_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid: got %0b expected 0", data_valid_d_o); end
    checks++; if (frame_start_d_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_fs_d: got %0b expected 0", frame_start_d_o); end
    checks++; if (sf_update_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_sf_update: got %0b expected 0", sf_update_o); end
    checks++; if (res_change_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_res_change: got %0b expected 0", res_change_o); end
    checks++; if (frame_start_encoder_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_fs_enc: got %0b expected 0", frame_start_encoder_o); end
    checks++; if (eof_encoder_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_eof: got %0b expected 0", eof_encoder_o); end
  endtask

  task automatic test_sf_timing;
    int first, pulses;
    run_frame(16'd1280, 16'd720, first, pulses);
    checks++; if (first != 27) begin failures++; $display("[TB] FAIL sf_latency: got %0d expected 27", first); end
    checks++; if (pulses != 1) begin failures++; $display("[TB] FAIL sf_pulse_count: got %0d expected 1", pulses); end
    checks++; if (h_scale_factor_o !== 16'd1535) begin failures++; $display("[TB] FAIL sf_1280_h: got %0d expected 1535", h_scale_factor_o); end
    checks++; if (v_scale_factor_o !== 16'd1535) begin failures++; $display("[TB] FAIL sf_720_v: got %0d expected 1535", v_scale_factor_o); end
    checks++; if (res_change_o !== 1'b0) begin failures++; $display("[TB] FAIL same_res_change: got %0b expected 0", res_change_o); end
  endtask

  task automatic test_sf_values;
    int first, pulses;
    run_frame(16'd1920, 16'd1072, first, pulses);
    checks++; if (h_scale_factor_o !== 16'd1023) begin failures++; $display("[TB] FAIL sf_1920_h: got %0d expected 1023", h_scale_factor_o); end
    checks++; if (v_scale_factor_o !== 16'd1030) begin failures++; $display("[TB] FAIL sf_1072_v: got %0d expected 1030", v_scale_factor_o); end
    checks++; if (res_change_o !== 1'b1) begin failures++; $display("[TB] FAIL new_res_change: got %0b expected 1", res_change_o); end
    run_frame(16'd640, 16'd480, first, pulses);
    checks++; if (h_scale_factor_o !== 16'd3071) begin failures++; $display("[TB] FAIL sf_640_h: got %0d expected 3071", h_scale_factor_o); end
    checks++; if (v_scale_factor_o !== 16'd2303) begin failures++; $display("[TB] FAIL sf_480_v: got %0d expected 2303", v_scale_factor_o); end
  endtask

  task automatic test_zero_res_restart;
    int first, pulses, early;
    early = 0;
    pulse_fs(16'd0, 16'd720);
    for (int n = 1; n <= 9; n++) begin
      if (sf_update_o) early++;
      tick();
    end
    run_frame(16'd0, 16'd1072, first, pulses);
    checks++; if (early + pulses != 1) begin failures++; $display("[TB] FAIL restart_pulse_count: got %0d expected 1", early + pulses); end
    checks++; if (first != 27) begin failures++; $display("[TB] FAIL restart_latency: got %0d expected 27", first); end
    checks++; if (h_scale_factor_o !== 16'd3071) begin failures++; $display("[TB] FAIL zero_h_hold: got %0d expected 3071", h_scale_factor_o); end
    checks++; if (v_scale_factor_o !== 16'd1030) begin failures++; $display("[TB] FAIL restart_v: got %0d expected 1030", v_scale_factor_o); end
  endtask

  task automatic test_data_pipe;
    logic [DW-1:0] dh [24];
    logic          vh [24];
    for (int n = 0; n < 24; n++) begin
      if (n >= DATA_DLY) begin
        checks++; if (data_d_o !== dh[n-DATA_DLY]) begin failures++; $display("[TB] FAIL data_delay c%0d: got %h expected %h", n, data_d_o, dh[n-DATA_DLY]); end
        checks++; if (data_valid_d_o !== vh[n-DATA_DLY]) begin failures++; $display("[TB] FAIL valid_delay c%0d: got %0b expected %0b", n, data_valid_d_o, vh[n-DATA_DLY]); end
      end
      checks++; if (frame_start_d_o !== (n == 3)) begin failures++; $display("[TB] FAIL fs_d c%0d: got %0b expected %0b", n, frame_start_d_o, (n == 3)); end
      checks++; if (frame_start_encoder_o !== (n == 18 || n == 19)) begin failures++; $display("[TB] FAIL fs_enc c%0d: got %0b expected %0b", n, frame_start_encoder_o, (n == 18 || n == 19)); end
      dh[n] = DW'($urandom);
      vh[n] = 1'($urandom_range(0, 1));
      data_i = dh[n];
      data_valid_i = vh[n];
      frame_start_i = (n == 0);
      tick();
    end
    data_valid_i = 1'b0;
  endtask

  task automatic test_encoder_flush;
    int rise;
    apply_reset();
    encoder_en_i = 1'b1;
    rise = -1;
    pulse_fs(16'd1280, 16'd720);
    for (int n = 1; n <= 39; n++) begin
      if (encoder_en_o && rise < 0) rise = n;
      tick();
    end
    checks++; if (rise != 5) begin failures++; $display("[TB] FAIL enc_rise: got %0d expected 5", rise); end
    pulse_fs(16'd1920, 16'd1072);
    for (int n = 1; n <= 39; n++) begin
      if (n == 1) begin checks++; if (eof_encoder_o !== 1'b1) begin failures++; $display("[TB] FAIL eof_on: got %0b expected 1", eof_encoder_o); end end
      if (n == 4) begin checks++; if (encoder_en_o !== 1'b1) begin failures++; $display("[TB] FAIL enc_before_flush: got %0b expected 1", encoder_en_o); end end
      if (n == 5) begin checks++; if (encoder_en_o !== 1'b0) begin failures++; $display("[TB] FAIL enc_flush: got %0b expected 0", encoder_en_o); end end
      if (n == 30) begin checks++; if (encoder_en_o !== 1'b0) begin failures++; $display("[TB] FAIL enc_flush_hold: got %0b expected 0", encoder_en_o); end end
      tick();
    end
    pulse_fs(16'd1920, 16'd1072);
    for (int n = 1; n <= 39; n++) begin
      if (n == 1) begin checks++; if (eof_encoder_o !== 1'b0) begin failures++; $display("[TB] FAIL eof_off: got %0b expected 0", eof_encoder_o); end end
      if (n == 4) begin checks++; if (encoder_en_o !== 1'b0) begin failures++; $display("[TB] FAIL enc_still_flush: got %0b expected 0", encoder_en_o); end end
      if (n == 5) begin checks++; if (encoder_en_o !== 1'b1) begin failures++; $display("[TB] FAIL enc_reenable: got %0b expected 1", encoder_en_o); end end
      tick();
    end
  endtask

  task automatic test_reset_mid;
    int pulses;
    data_valid_i = 1'b1;
    data_i = 32'hA5A5_5A5A;
    pulse_fs(16'd1920, 16'd1072);
    for (int n = 1; n <= 9; n++) tick();
    checks++; if (data_d_o !== 32'hA5A5_5A5A) begin failures++; $display("[TB] FAIL pre_reset_data: got %h expected a5a55a5a", data_d_o); end
    checks++; if (encoder_en_o !== 1'b1) begin failures++; $display("[TB] FAIL pre_reset_enc: got %0b expected 1", encoder_en_o); end
    #2 resetn_i = 1'b0;
    #1;
    checks++; if (encoder_en_o !== 1'b0) begin failures++; $display("[TB] FAIL mid_reset_enc: got %0b expected 0", encoder_en_o); end
    checks++; if (data_d_o !== '0) begin failures++; $display("[TB] FAIL mid_reset_data: got %h expected 0", data_d_o); end
    checks++; if (data_valid_d_o !== 1'b0) begin failures++; $display("[TB] FAIL mid_reset_valid: got %0b expected 0", data_valid_d_o); end
    data_valid_i = 1'b0;
    data_i = '0;
    tick();
    tick();
    #2 resetn_i = 1'b1;
    pulses = 0;
    for (int n = 0; n < 35; n++) begin
      if (sf_update_o) pulses++;
      tick();
    end
    checks++; if (pulses != 0) begin failures++; $display("[TB] FAIL aborted_sf_update: got %0d expected 0", pulses); end
    checks++; if (h_scale_factor_o !== 16'd1535) begin failures++; $display("[TB] FAIL post_reset_h: got %0d expected 1535", h_scale_factor_o); end
    checks++; if (v_scale_factor_o !== 16'd1534) begin failures++; $display("[TB] FAIL post_reset_v: got %0d expected 1534", v_scale_factor_o); end
  endtask

  initial begin
    test_reset();
    test_sf_timing();
    test_sf_values();
    test_zero_res_restart();
    test_data_pipe();
    test_encoder_flush();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
